ad9516_init_supervisor: RTL
===========================

# ad9516_init_supervisor

Power-up and lock supervisor for the AD9516 clock generator. It sits directly upstream of the AD9516 SPI wrapper and drives that wrapper's `spi_write_start` input. After reset it waits for the rails to settle, then triggers the full SPI register load. It then watches the AD9516 LD (lock-detect) pin and re-triggers configuration on lock timeout, lock loss or a software request. It reports locked, done and fail status to the rest of the FPGA.

## Interface
Parameters:
- `POR_WAIT_CYC`, 1_000_000: cycles from reset release to the first configuration trigger.
- `CFG_WAIT_CYC`, 2_000_000: cycles allowed for the SPI wrapper to finish the register load (the wrapper has no done flag).
- `LOCK_TIMEOUT_CYC`, 5_000_000: cycles in LOCK_WAIT before the attempt is declared failed.
- `LOCK_FILT_CYC`, 1024: consecutive stable samples required to change the filtered lock state.
- `MAX_RETRY`, 3: retries allowed after the first attempt before entering FAIL (range 0-15).

Ports:
- `sys_clk_i`  in  1  system clock, the same clock as the SPI wrapper.
- `rst_n_i`  in  1  reset; one clock; reset is asynchronous and active-low.
- `ld_i`  in  1  AD9516 LD pin; asynchronous to `sys_clk_i`.
- `rerun_i`  in  1  software re-configure request; acts on its rising edge.
- `spi_write_start_o`  out  1  to wrapper `spi_write_start`; a high level lasting `START_HOLD` cycles.
- `pll_locked_o`  out  1  filtered lock status.
- `init_done_o`  out  1  high while in LOCKED.
- `init_fail_o`  out  1  high while in FAIL.
- `retry_cnt_o`  out  4  retries used in the current sequence.
- `state_o`  out  3  current state encoding, for debug/ILA.

## Operation
- `ld_i` passes through a 2-FF synchronizer and then a debounce filter.
  - `lock_filt` sets after `LOCK_FILT_CYC` consecutive high samples.
  - `lock_filt` clears after `LOCK_FILT_CYC` consecutive low samples.
  - Any opposite sample restarts the count.
- `rerun_i` is registered; `rerun_rise = rerun_i & ~rerun_q`.
- One shared down-counter serves all timed states. It is reloaded on every state entry.
- State encodings: POR_WAIT=0, TRIGGER=1, CFG_WAIT=2, LOCK_WAIT=3, LOCKED=4, FAIL=5.
- State transitions:
  - POR_WAIT: after `POR_WAIT_CYC` cycles, go to TRIGGER.
  - TRIGGER: hold `spi_write_start_o`=1 for `START_HOLD`(=4) cycles, then go to CFG_WAIT.
  - CFG_WAIT: after `CFG_WAIT_CYC` cycles, go to LOCK_WAIT.
  - LOCK_WAIT, `lock_filt`=1: go to LOCKED.
  - LOCK_WAIT, `LOCK_TIMEOUT_CYC` elapsed and `retry_cnt` < `MAX_RETRY`: increment `retry_cnt`, go to TRIGGER.
  - LOCK_WAIT, timeout otherwise: go to FAIL.
  - LOCKED, `lock_filt` falls: clear `retry_cnt`, go to TRIGGER.
  - LOCKED, `rerun_rise`: clear `retry_cnt`, go to TRIGGER.
  - FAIL: `rerun_rise` clears `retry_cnt` and goes to TRIGGER; otherwise remain in FAIL.
- `rerun_rise` in POR_WAIT, TRIGGER, CFG_WAIT or LOCK_WAIT is ignored; a sequence is already in progress.
- In LOCKED, if lock loss and `rerun_rise` occur in the same cycle, the result is one transition to TRIGGER with `retry_cnt` cleared.
- In LOCK_WAIT, if lock and timeout occur in the same cycle, lock wins and the FSM goes to LOCKED.
- Counter widths are `$clog2` of the largest timed parameter + 1. No wrap-around is possible because the counter reloads on every state entry.

## Timing
- All outputs are registered.
- Reset values: `spi_write_start_o`=0, `pll_locked_o`=0, `init_done_o`=0, `init_fail_o`=0, `retry_cnt_o`=0, `state_o`=0 (POR_WAIT). Synchronizer, filter and counters are also cleared.
- First `spi_write_start_o` rise occurs `POR_WAIT_CYC`+1 cycles after `rst_n_i` deasserts.
- `spi_write_start_o` is low for at least `CFG_WAIT_CYC` cycles between pulses. This guarantees a clean edge for the wrapper's pulse detector.
- `ld_i` to `pll_locked_o` latency: 2 (sync) + `LOCK_FILT_CYC` + 1 cycles.
- `init_done_o` rises 1 cycle after `lock_filt` rises while in LOCK_WAIT.
- Reset asserted mid-operation, including mid-TRIGGER, forces all outputs low immediately. Because `rst_n_i` also drives the AD9516 RESET_B pin, the device restarts in step.

## Structure
- Shared package `ad9516_pkg` holds:
  - the state encoding constants;
  - `START_HOLD`=4;
  - the width function for the counter.
- Sub-module `ad9516_lock_filter` contains the 2-FF synchronizer and symmetric debounce, parameterised by `LOCK_FILT_CYC`. It outputs `lock_filt`.
- The top level holds the FSM, the shared counter, `retry_cnt` and the rerun edge detect.

## Test plan
All scenarios use `POR_WAIT_CYC`=16, `CFG_WAIT_CYC`=32, `LOCK_TIMEOUT_CYC`=64, `LOCK_FILT_CYC`=8, `MAX_RETRY`=2.
- Nominal: release reset, assert `ld_i` 10 cycles into LOCK_WAIT.
  - `spi_write_start_o` is high for cycles 17-20.
  - `init_done_o` and `pll_locked_o` are 1 within 11 further cycles.
  - `retry_cnt_o`=0.
- Never lock: hold `ld_i`=0.
  - Exactly 3 trigger pulses occur, with `retry_cnt_o` stepping 0→1→2.
  - The FSM then enters FAIL with `init_fail_o`=1, `state_o`=5 and no further pulses.
- Glitchy LD: drive `ld_i` high for 7 cycles, low 1, high 7 → `pll_locked_o` stays 0.
- Lock loss: from LOCKED, drive `ld_i` low for 8 cycles.
  - `pll_locked_o` falls and `init_done_o` falls.
  - A new trigger pulse follows with `retry_cnt_o`=0.
- Rerun handling:
  - `rerun_i` held high during CFG_WAIT → ignored, no extra pulse.
  - A rising edge in FAIL → one pulse, `init_fail_o`=0.
- Reset mid-TRIGGER (2nd pulse cycle) → `spi_write_start_o`=0 asynchronously; after release the FSM restarts at POR_WAIT.

Source files
------------

// File: rtl/ad9516_pkg.sv
// ============================================================================
// Module  : ad9516_pkg
// Brief   : Shared state encoding, trigger hold length and counter sizing
//           for the AD9516 init supervisor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ad9516_pkg;

  // Supervisor states; the encoding is visible on the debug state port.
  typedef enum logic [2:0] {
    ST_POR_WAIT  = 3'd0,
    ST_TRIGGER   = 3'd1,
    ST_CFG_WAIT  = 3'd2,
    ST_LOCK_WAIT = 3'd3,
    ST_LOCKED    = 3'd4,
    ST_FAIL      = 3'd5
  } state_t;

  // Cycles the SPI wrapper start level is held high.
  localparam int START_HOLD = 4;

  // Down-counter width able to hold the largest of the timed intervals.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = START_HOLD;
    if (a > m) m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ad9516_lock_filter.sv
// ============================================================================
// Module  : ad9516_lock_filter
// Brief   : Two-flop synchronizer for the AD9516 LD pin followed by a
//           symmetric debounce: the filtered level only changes after
//           LOCK_FILT_CYC consecutive samples of the opposite level.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ad9516_lock_filter
  import ad9516_pkg::*;
#(
  parameter int LOCK_FILT_CYC = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ld_async,
  output logic lock_filt
);

  localparam int FW = cnt_width(LOCK_FILT_CYC, 1, 1);

  logic          ld_meta;
  logic          ld_sync;
  logic [FW-1:0] run_cnt;

  // Bring the asynchronous LD pin into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_meta <= 1'b0;
      ld_sync <= 1'b0;
    end else begin
      ld_meta <= ld_async;
      ld_sync <= ld_meta;
    end
  end

  // Count consecutive samples that disagree with the filtered level; a
  // sample that agrees restarts the run, a full run flips the level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt   <= '0;
      lock_filt <= 1'b0;
    end else if (ld_sync == lock_filt) begin
      run_cnt <= '0;
    end else if (run_cnt == FW'(LOCK_FILT_CYC - 1)) begin
      run_cnt   <= '0;
      lock_filt <= ld_sync;
    end else begin
      run_cnt <= run_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ad9516_init_supervisor.sv
// ============================================================================
// Module  : ad9516_init_supervisor
// Brief   : Power-up and lock supervisor for the AD9516. Waits for the rails,
//           triggers the SPI register load, watches the filtered lock
//           detect and re-triggers on timeout, lock loss or software rerun.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ad9516_init_supervisor
  import ad9516_pkg::*;
#(
  parameter int POR_WAIT_CYC     = 1_000_000,
  parameter int CFG_WAIT_CYC     = 2_000_000,
  parameter int LOCK_TIMEOUT_CYC = 5_000_000,
  parameter int LOCK_FILT_CYC    = 1024,
  parameter int MAX_RETRY        = 3
) (
  input  logic       sys_clk_i,
  input  logic       rst_n_i,
  input  logic       ld_i,
  input  logic       rerun_i,
  output logic       spi_write_start_o,
  output logic       pll_locked_o,
  output logic       init_done_o,
  output logic       init_fail_o,
  output logic [3:0] retry_cnt_o,
  output logic [2:0] state_o
);

  localparam int         CNT_W       = cnt_width(POR_WAIT_CYC, CFG_WAIT_CYC, LOCK_TIMEOUT_CYC);
  localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_reload;
  logic               cnt_zero;
  logic [3:0]         retry_cnt;
  logic [3:0]         retry_next;
  logic               rerun_q;
  logic               rerun_rise;
  logic               lock_filt;

  ad9516_lock_filter #(
    .LOCK_FILT_CYC (LOCK_FILT_CYC)
  ) u_lock_filter (
    .clk       (sys_clk_i),
    .rst_n     (rst_n_i),
    .ld_async  (ld_i),
    .lock_filt (lock_filt)
  );

  assign rerun_rise = rerun_i & ~rerun_q;
  assign cnt_zero   = (cnt == '0);

  // Rerun edge detector.
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rerun_q <= 1'b0;
    else          rerun_q <= rerun_i;
  end

  // State, retry count and registered status outputs.
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state             <= ST_POR_WAIT;
      retry_cnt         <= '0;
      spi_write_start_o <= 1'b0;
      init_done_o       <= 1'b0;
      init_fail_o       <= 1'b0;
      pll_locked_o      <= 1'b0;
    end else begin
      state             <= next_state;
      retry_cnt         <= retry_next;
      spi_write_start_o <= (next_state == ST_TRIGGER);
      init_done_o       <= (next_state == ST_LOCKED);
      init_fail_o       <= (next_state == ST_FAIL);
      pll_locked_o      <= lock_filt;
    end
  end

  // Shared down-counter: reloaded whenever the state changes. The reset
  // value is POR_WAIT_CYC so the first start rise lands POR_WAIT_CYC+1
  // cycles after reset release; other states stay exactly their length.
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                 cnt <= CNT_W'(POR_WAIT_CYC);
    else if (next_state != state) cnt <= cnt_reload;
    else if (!cnt_zero)           cnt <= cnt - 1'b1;
  end

  // Counter reload value for the state about to be entered.
  always_comb begin
    cnt_reload = '0;
    case (next_state)
      ST_TRIGGER:   cnt_reload = CNT_W'(START_HOLD - 1);
      ST_CFG_WAIT:  cnt_reload = CNT_W'(CFG_WAIT_CYC - 1);
      ST_LOCK_WAIT: cnt_reload = CNT_W'(LOCK_TIMEOUT_CYC - 1);
      default:      cnt_reload = '0;
    endcase
  end

  // Next-state and retry bookkeeping; rerun only acts in LOCKED and FAIL,
  // and lock takes priority over a coincident timeout.
  always_comb begin
    next_state = state;
    retry_next = retry_cnt;
    case (state)
      ST_POR_WAIT: if (cnt_zero) next_state = ST_TRIGGER;
      ST_TRIGGER:  if (cnt_zero) next_state = ST_CFG_WAIT;
      ST_CFG_WAIT: if (cnt_zero) next_state = ST_LOCK_WAIT;
      ST_LOCK_WAIT: begin
        if (lock_filt) begin
          next_state = ST_LOCKED;
        end else if (cnt_zero) begin
          if (retry_cnt < RETRY_LIMIT) begin
            retry_next = retry_cnt + 1'b1;
            next_state = ST_TRIGGER;
          end else begin
            next_state = ST_FAIL;
          end
        end
      end
      ST_LOCKED: begin
        if (!lock_filt || rerun_rise) begin
          retry_next = '0;
          next_state = ST_TRIGGER;
        end
      end
      ST_FAIL: begin
        if (rerun_rise) begin
          retry_next = '0;
          next_state = ST_TRIGGER;
        end
      end
      default: next_state = ST_POR_WAIT;
    endcase
  end

  assign retry_cnt_o = retry_cnt;
  assign state_o     = state;

endmodule

`default_nettype wire
